// File: rtl/math_pipelined_alu.sv
// Chunked, fully pipelined ALU. Each stage resolves one ALU_WIDTH-bit slice
// of the operation, so the longest carry chain is one chunk wide. Operands
// travel skewed ahead of the stage that consumes them; finished result chunks
// ride along until the last stage, so every bit of an operation emerges together.
module math_pipelined_alu #(
  parameter int WIDTH     = 16,
  parameter int LATENCY   = 4,
  parameter int TAG_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [2:0]           op,
  input  logic                 cin,
  input  logic [WIDTH-1:0]     I1,
  input  logic [WIDTH-1:0]     I2,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     result,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int LAT_EFF         = (LATENCY > WIDTH) ? WIDTH : LATENCY;
  localparam int ALU_WIDTH       = (WIDTH + LAT_EFF - 1) / LAT_EFF;
  localparam int CHUNK_COUNT     = (WIDTH + ALU_WIDTH - 1) / ALU_WIDTH;
  localparam int LAST_CHUNK_SIZE = WIDTH - (CHUNK_COUNT - 1) * ALU_WIDTH;
  // Operands are zero-padded to a whole number of chunks; the padding keeps
  // the carry out of bit WIDTH-1 visible at bit LAST_CHUNK_SIZE of the last sum.
  localparam int PAD_WIDTH       = CHUNK_COUNT * ALU_WIDTH;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  // c holds the carry out of the stage that produced the record; for SUB it
  // is an inverted borrow because subtraction runs as I1 + ~I2 + ~cin.
  typedef struct packed {
    logic                 valid;
    logic [2:0]           op;
    logic [TAG_WIDTH-1:0] tag;
    logic [PAD_WIDTH-1:0] a;
    logic [PAD_WIDTH-1:0] b;
    logic [PAD_WIDTH-1:0] res;
    logic                 c;
    logic                 z;
    logic                 sa;
    logic                 sb;
    logic                 cout;
    logic                 ovf;
  } stage_t;

  stage_t in_stage;
  stage_t link [CHUNK_COUNT+1];
  stage_t last;
  logic   unused_last;

  // Normalise the incoming operation; empty slots carry all-zero data so
  // bubbles never propagate X.
  always_comb begin
    in_stage = '0;
    if (in_valid) begin
      in_stage.valid            = 1'b1;
      in_stage.op               = (op > OP_XOR) ? OP_ADD : op;
      in_stage.tag              = in_tag;
      in_stage.a[WIDTH-1:0]     = I1;
      in_stage.b[WIDTH-1:0]     = (op == OP_SUB) ? ~I2 : I2;
      in_stage.c                = (op == OP_SUB) ? ~cin : cin;
      in_stage.z                = 1'b1;
      in_stage.sa               = I1[WIDTH-1];
      in_stage.sb               = I2[WIDTH-1];
    end
  end

  assign link[0] = in_stage;

  for (genvar s = 0; s < CHUNK_COUNT; s++) begin : g_stage
    localparam int CB = (s == CHUNK_COUNT - 1) ? LAST_CHUNK_SIZE : ALU_WIDTH;
    localparam logic [ALU_WIDTH-1:0] CH_MASK = {ALU_WIDTH{1'b1}} >> (ALU_WIDTH - CB);

    stage_t                 prev;
    stage_t                 st_d;
    stage_t                 st_q;
    logic [ALU_WIDTH:0]     sum;
    logic [ALU_WIDTH-1:0]   a_c;
    logic [ALU_WIDTH-1:0]   b_c;
    logic [ALU_WIDTH-1:0]   ch_raw;
    logic [ALU_WIDTH-1:0]   ch;
    logic                   sr;
    logic                   unused_sum;

    assign prev       = link[s];
    assign unused_sum = ^sum;

    // Resolve chunk s, fold it into the zero flag, and form final flags
    // (only the last stage's flags reach the outputs).
    always_comb begin
      st_d   = prev;
      a_c    = prev.a[s*ALU_WIDTH +: ALU_WIDTH];
      b_c    = prev.b[s*ALU_WIDTH +: ALU_WIDTH];
      sum    = {1'b0, a_c} + {1'b0, b_c} + {{ALU_WIDTH{1'b0}}, prev.c};
      case (prev.op)
        OP_AND:  ch_raw = a_c & b_c;
        OP_OR:   ch_raw = a_c | b_c;
        OP_XOR:  ch_raw = a_c ^ b_c;
        default: ch_raw = sum[ALU_WIDTH-1:0];
      endcase
      ch     = ch_raw & CH_MASK;
      sr     = ch[CB-1];
      st_d.res[s*ALU_WIDTH +: ALU_WIDTH] = ch;
      st_d.c    = sum[CB];
      st_d.z    = prev.z & (ch == '0);
      st_d.cout = 1'b0;
      st_d.ovf  = 1'b0;
      case (prev.op)
        OP_ADD: begin
          st_d.cout = sum[CB];
          st_d.ovf  = (prev.sa == prev.sb) && (sr != prev.sa);
        end
        OP_SUB: begin
          st_d.cout = ~sum[CB];
          st_d.ovf  = (prev.sa != prev.sb) && (sr != prev.sa);
        end
        default: ;
      endcase
    end

    // Stage register; reset wins over ce and drops in-flight operations.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q <= '0;
      end else if (ce) begin
        st_q <= st_d;
      end
    end

    assign link[s+1] = st_q;
  end

  assign last        = link[CHUNK_COUNT];
  assign out_valid   = last.valid;
  assign result      = last.res[WIDTH-1:0];
  assign cout        = last.cout;
  assign ovf         = last.ovf;
  assign zero        = last.z;
  assign out_tag     = last.tag;
  assign unused_last = ^last;

endmodule

// File: tb/tb_math_pipelined_alu.sv
module tb_math_pipelined_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ce;

  // 16-bit, 4-stage instance
  logic        v16, cin16;
  logic [2:0]  op16, tag16;
  logic [15:0] a16, b16;
  logic        ov16, co16, of16, zr16;
  logic [15:0] res16;
  logic [2:0]  otag16;
  logic [22:0] obs16;

  // 10-bit instances (3-stage and single-stage) share inputs
  logic        v10, cin10, tag10;
  logic [2:0]  op10;
  logic [9:0]  a10, b10;
  logic        d_ov, d_co, d_of, d_zr, d_tag;
  logic [9:0]  d_res;
  logic        s_ov, s_co, s_of, s_zr, s_tag;
  logic [9:0]  s_res;
  logic [14:0] obs_d, obs_s;

  int checks = 0;
  int errors = 0;

  math_pipelined_alu #(.WIDTH(16), .LATENCY(4), .TAG_WIDTH(3)) dut16 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(v16), .op(op16), .cin(cin16),
    .I1(a16), .I2(b16), .in_tag(tag16), .out_valid(ov16), .result(res16),
    .cout(co16), .ovf(of16), .zero(zr16), .out_tag(otag16));

  math_pipelined_alu #(.WIDTH(10), .LATENCY(3), .TAG_WIDTH(1)) dut10 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(v10), .op(op10), .cin(cin10),
    .I1(a10), .I2(b10), .in_tag(tag10), .out_valid(d_ov), .result(d_res),
    .cout(d_co), .ovf(d_of), .zero(d_zr), .out_tag(d_tag));

  math_pipelined_alu #(.WIDTH(10), .LATENCY(1), .TAG_WIDTH(1)) dut10_l1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(v10), .op(op10), .cin(cin10),
    .I1(a10), .I2(b10), .in_tag(tag10), .out_valid(s_ov), .result(s_res),
    .cout(s_co), .ovf(s_of), .zero(s_zr), .out_tag(s_tag));

  assign obs16 = {ov16, otag16, co16, of16, zr16, res16};
  assign obs_d = {d_ov, d_tag, d_co, d_of, d_zr, d_res};
  assign obs_s = {s_ov, s_tag, s_co, s_of, s_zr, s_res};

  // Full-width reference: {cout, ovf, zero, result}
  function automatic logic [18:0] ref16(input logic [2:0] o, input logic [15:0] a,
                                        input logic [15:0] b, input logic c);
    logic [16:0] w;
    logic [15:0] r;
    logic        co, ov;
    co = 1'b0;
    ov = 1'b0;
    w  = '0;
    case (o)
      3'd1: begin
        w  = {1'b0, a} - {1'b0, b} - {16'b0, c};
        r  = w[15:0];
        co = w[16];
        ov = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: begin
        w  = {1'b0, a} + {1'b0, b} + {16'b0, c};
        r  = w[15:0];
        co = w[16];
        ov = (a[15] == b[15]) && (r[15] != a[15]);
      end
    endcase
    return {co, ov, (r == 16'h0000), r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic run16(input string name, input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic c, input logic [2:0] t,
                       input logic [18:0] exp);
    v16 = 1'b1; op16 = o; a16 = a; b16 = b; cin16 = c; tag16 = t;
    tick();
    v16 = 1'b0;
    tick();
    tick();
    check({name, "_early"}, {31'b0, ov16}, 32'd0);
    tick();
    check(name, {9'b0, obs16}, {9'b0, 1'b1, t, exp});
  endtask

  task automatic run10(input string name, input logic [2:0] o, input logic [9:0] a,
                       input logic [9:0] b, input logic c, input logic t,
                       input logic [12:0] exp);
    v10 = 1'b1; op10 = o; a10 = a; b10 = b; cin10 = c; tag10 = t;
    tick();
    v10 = 1'b0;
    check({name, "_lat1"}, {17'b0, obs_s}, {17'b0, 1'b1, t, exp});
    check({name, "_l3_early1"}, {31'b0, d_ov}, 32'd0);
    tick();
    check({name, "_lat1_bubble"}, {31'b0, s_ov}, 32'd0);
    check({name, "_l3_early2"}, {31'b0, d_ov}, 32'd0);
    tick();
    check({name, "_lat3"}, {17'b0, obs_d}, {17'b0, 1'b1, t, exp});
  endtask

  logic [2:0]  s_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd4};
  logic [15:0] s_a   [8] = '{16'h1234, 16'hF00D, 16'hBEEF, 16'h0F0F,
                             16'h8001, 16'h7FFF, 16'hFFFF, 16'hA5A5};
  logic [15:0] s_b   [8] = '{16'h4321, 16'h0FFE, 16'h1357, 16'hFFFF,
                             16'h8000, 16'hFFFF, 16'h0001, 16'h5A5A};
  logic        s_cin [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [31:0] ce_pat;
    int en, issued, k;

    rst = 1'b1; ce = 1'b1;
    v16 = 1'b0; op16 = '0; cin16 = 1'b0; a16 = '0; b16 = '0; tag16 = '0;
    v10 = 1'b0; op10 = '0; cin10 = 1'b0; a10 = '0; b10 = '0; tag10 = 1'b0;
    tick();
    tick();
    check("reset_16", {9'b0, obs16}, 32'd0);
    check("reset_10_l3", {17'b0, obs_d}, 32'd0);
    check("reset_10_l1", {17'b0, obs_s}, 32'd0);
    rst = 1'b0;

    // Directed 16-bit vectors, expected {cout, ovf, zero, result}
    run16("add_wrap",     3'd0, 16'hFFFF, 16'h0001, 1'b0, 3'd1, {1'b1, 1'b0, 1'b1, 16'h0000});
    run16("add_ovf",      3'd0, 16'h7FFF, 16'h0001, 1'b0, 3'd2, {1'b0, 1'b1, 1'b0, 16'h8000});
    run16("sub_borrow",   3'd1, 16'h0000, 16'h0001, 1'b0, 3'd3, {1'b1, 1'b0, 1'b0, 16'hFFFF});
    run16("sub_ovf",      3'd1, 16'h8000, 16'h0001, 1'b0, 3'd4, {1'b0, 1'b1, 1'b0, 16'h7FFF});
    run16("add_cin",      3'd0, 16'h1234, 16'h0001, 1'b1, 3'd5, {1'b0, 1'b0, 1'b0, 16'h1236});
    run16("sub_bin",      3'd1, 16'h0005, 16'h0005, 1'b1, 3'd6, {1'b1, 1'b0, 1'b0, 16'hFFFF});
    run16("sub_eq",       3'd1, 16'h0005, 16'h0005, 1'b0, 3'd7, {1'b0, 1'b0, 1'b1, 16'h0000});
    run16("add_chunk",    3'd0, 16'h00FF, 16'h0001, 1'b0, 3'd0, {1'b0, 1'b0, 1'b0, 16'h0100});
    run16("and",          3'd2, 16'hF0F0, 16'h0FF0, 1'b1, 3'd1, {1'b0, 1'b0, 1'b0, 16'h00F0});
    run16("or",           3'd3, 16'hF0F0, 16'h0F0F, 1'b0, 3'd2, {1'b0, 1'b0, 1'b0, 16'hFFFF});
    run16("xor_zero",     3'd4, 16'hAAAA, 16'hAAAA, 1'b1, 3'd3, {1'b0, 1'b0, 1'b1, 16'h0000});
    run16("op7_as_add",   3'd7, 16'h0001, 16'h0002, 1'b0, 3'd4, {1'b0, 1'b0, 1'b0, 16'h0003});

    // Back-to-back stream: op k enters at tick k and leaves after tick k+3
    for (int t = 0; t < 12; t++) begin
      if (t < 8) begin
        v16 = 1'b1; op16 = s_op[t]; a16 = s_a[t]; b16 = s_b[t];
        cin16 = s_cin[t]; tag16 = 3'(t);
      end else begin
        v16 = 1'b0;
      end
      tick();
      if (t >= 3 && t < 11)
        check("stream", {9'b0, obs16},
              {9'b0, 1'b1, 3'(t - 3), ref16(s_op[t-3], s_a[t-3], s_b[t-3], s_cin[t-3])});
      else
        check("stream_idle", {31'b0, ov16}, 32'd0);
    end

    // Same stream with ce stalls; producer holds each op until it is taken
    ce_pat = 32'b1011_0110_1110_0101_1101_1011_0111_1010;
    en = 0;
    issued = 0;
    for (int cyc = 0; cyc < 64 && en < 11; cyc++) begin
      ce = ce_pat[cyc % 32];
      if (issued < 8) begin
        v16 = 1'b1; op16 = s_op[issued]; a16 = s_a[issued]; b16 = s_b[issued];
        cin16 = s_cin[issued]; tag16 = 3'(issued);
      end else begin
        v16 = 1'b0;
      end
      tick();
      if (ce) begin
        en++;
        if (issued < 8) issued++;
      end
      k = en - 4;
      if (k >= 0 && k < 8)
        check("stall_out", {9'b0, obs16},
              {9'b0, 1'b1, 3'(k), ref16(s_op[k], s_a[k], s_b[k], s_cin[k])});
      else
        check("stall_idle", {31'b0, ov16}, 32'd0);
    end
    check("stall_edges", 32'(en), 32'd11);
    ce = 1'b1;
    v16 = 1'b0;

    // Reset with three ops in flight; held with ce=0 to show reset priority
    for (int t = 0; t < 3; t++) begin
      v16 = 1'b1; op16 = 3'd0; a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0;
      tag16 = 3'(5 + t);
      tick();
    end
    v16 = 1'b0;
    rst = 1'b1;
    ce  = 1'b0;
    tick();
    check("rst_clear", {9'b0, obs16}, 32'd0);
    rst = 1'b0;
    ce  = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      check("rst_no_ghost", {31'b0, ov16}, 32'd0);
    end
    run16("post_rst", 3'd0, 16'h4000, 16'h4000, 1'b0, 3'd6, {1'b0, 1'b1, 1'b0, 16'h8000});

    // 10-bit instances: 3 stages with a 2-bit last chunk, and a single stage
    run10("w10_add_wrap", 3'd0, 10'h3FF, 10'h001, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 10'h000});
    run10("w10_sub",      3'd1, 10'h000, 10'h001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 10'h3FF});
    run10("w10_add_ovf",  3'd0, 10'h1FF, 10'h001, 1'b0, 1'b1, {1'b0, 1'b1, 1'b0, 10'h200});
    run10("w10_sub_ovf",  3'd1, 10'h200, 10'h001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 10'h1FF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/math_pipelined_alu.md
# math_pipelined_alu

Parametrised successor to the toolbox pipelined adder. Fully pipelined chunked ALU with configurable width and latency: ADD/SUB with carry-in, AND/OR/XOR, and carry, overflow and zero flags. Valid/tag sideband travels with each operation. Accepts one operation per enabled cycle and sits between register-file style operand sources and wide counters/accumulators, where full-width carry chains would miss timing.

## Interface
- WIDTH, 16: operand/result width, ≥1.
- LATENCY, 4: requested pipeline depth, ≥1; values > WIDTH behave as WIDTH.
- TAG_WIDTH, 1: width of the opaque sideband tag, ≥1.
- Derived: ALU_WIDTH = ceil(WIDTH/LATENCY); CHUNK_COUNT = ceil(WIDTH/ALU_WIDTH); LAST_CHUNK_SIZE = WIDTH − (CHUNK_COUNT−1)·ALU_WIDTH.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  pipeline advance enable; low = whole pipeline holds.
- in_valid  in  1  operation present on I1/I2/op/cin/in_tag.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5–7 execute as ADD.
- cin  in  1  carry-in (ADD) / borrow-in (SUB); ignored for logic ops.
- I1, I2  in  WIDTH  operands; SUB computes I1 − I2 − cin.
- in_tag  in  TAG_WIDTH  sideband, returned unchanged.
- out_valid  out  1  result/flags/out_tag valid.
- result  out  WIDTH  operation result, modulo 2^WIDTH.
- cout  out  1  ADD: carry out of bit WIDTH−1; SUB: borrow (1 iff I1 < I2+cin unsigned); logic ops: 0.
- ovf  out  1  two's-complement overflow for ADD/SUB; 0 for logic ops.
- zero  out  1  result == 0.
- out_tag  out  TAG_WIDTH  tag of the operation on the outputs.

## Operation
- Stage s (0..CHUNK_COUNT−1) computes chunk s: bits [s·ALU_WIDTH +: ALU_WIDTH], last chunk LAST_CHUNK_SIZE bits.
- Carry/borrow from stage s is registered and consumed by stage s+1 in the next cycle. Stage 0 consumes cin.
- Operand chunks not yet consumed are delay-registered (skewed). Completed result chunks are delay-registered (deskewed), so all bits of one operation emerge together.
- op, valid, tag, and the operand sign bits travel alongside the skewed operands through every stage.
- Zero flag accumulates per stage: z_s = z_(s−1) & (chunk_s == 0).
- Overflow is computed in the last stage:
  - ADD: sign(I1)==sign(I2) && sign(result)!=sign(I1).
  - SUB: sign(I1)!=sign(I2) && sign(result)!=sign(I1).
- Invalid slots (in_valid=0) still advance when ce=1 and produce out_valid=0. Their data outputs are don't-care but must be deterministic (no X).
- No backpressure output: the producer is responsible for holding in_valid/operands while ce=0.

## Timing
- Reset: out_valid=0, result=0, cout=0, ovf=0, zero=0, out_tag=0. All internal valid bits clear; in-flight operations are dropped.
- rst has priority over ce.
- Latency: an operation sampled with ce=1, in_valid=1 at edge t appears at outputs after edge t+CHUNK_COUNT−1, i.e. CHUNK_COUNT enabled edges.
- Throughput: one operation per ce=1 cycle; back-to-back operations must never interfere, since each carry belongs to its own operation.
- ce=0: every register holds, including outputs and out_valid. Latency counts only enabled edges.
- LATENCY=1: single stage, full-width operation, latency 1.
- WIDTH not divisible by ALU_WIDTH: the last chunk is narrower, and cout/ovf are taken from bit WIDTH−1.
- Flags and result are valid in the same cycle as out_valid.

## Test plan
- WIDTH=16, LATENCY=4: ADD 0xFFFF+0x0001, cin=0, tag=1 -> exactly 4 enabled cycles later, out_valid=1, result=0x0000, cout=1, zero=1, ovf=0, out_tag=1.
- ADD 0x7FFF+0x0001 -> result 0x8000, ovf=1, cout=0. SUB 0x0000−0x0001 -> 0xFFFF, cout=1, ovf=0. SUB 0x8000−0x0001 -> 0x7FFF, ovf=1.
- Streaming: 8 consecutive ops alternating ADD/SUB/AND/XOR with random operands and tags 0..7 -> 8 consecutive out_valid cycles, in order, matching the reference model bit-exactly.
- ce toggled pseudo-randomly during streaming -> outputs and out_valid frozen while ce=0; results unchanged vs the no-stall run.
- rst asserted for 1 cycle with 3 ops in flight -> next cycle all outputs 0; no dropped op ever appears; a new op after reset has normal latency.
- WIDTH=10, LATENCY=3 (ALU_WIDTH=4, last chunk 2 bits): ADD 0x3FF+0x001 -> result 0x000, cout=1, after 3 cycles. LATENCY=1: same op -> latency 1.
